dual_priority_encode_seq: RTL



---
 rtl/dual_priority_encode_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dual_priority_encode_seq.sv
// dual_priority_encode_seq
//
// Sequential dual priority encoder. It captures a 12-bit request vector and
// walks it from bit 11 down to bit 0, one bit per clock. The encoder reports
// the codes of the highest and second-highest set bits. Bit n is reported as
// code n+1, and code 0 means "none".
//
// The scan always takes exactly 12 cycles, whatever the request contains.
// The result is then held until the downstream side accepts it.
//
// Ports
//   i_clk     : clock, all state changes on the rising edge
//   i_reset   : synchronous active-high reset
//   i_req     : 12-bit request vector (bit 11 = highest priority)
//   i_valid   : upstream request strobe, sampled only while idle
//   o_ready   : block is idle and will accept a request
//   o_first   : code of the highest set bit (0 = none)
//   o_second  : code of the second-highest set bit (0 = none)
//   o_none    : captured request had no bits set
//   o_valid   : o_first / o_second / o_none are valid
//   i_ready   : downstream accepts the result while o_valid is high
module dual_priority_encode_seq (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [11:0] i_req,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [3:0]  o_first,
    output logic [3:0]  o_second,
    output logic        o_none,
    output logic        o_valid,
    input  logic        i_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] req_q, req_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  first_q, first_d;
    logic [3:0]  second_q, second_d;

    logic        o_ready_q, o_ready_d;
    logic        o_valid_q, o_valid_d;
    logic [3:0]  o_first_q, o_first_d;
    logic [3:0]  o_second_q, o_second_d;
    logic        o_none_q, o_none_d;

    // Next-state, scan datapath and next output values.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        second_d = second_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    req_d    = i_req;
                    cnt_d    = 4'd11;
                    first_d  = 4'd0;
                    second_d = 4'd0;
                    state_d  = SCAN;
                end else begin
                    state_d  = IDLE;
                end
            end
            SCAN: begin
                // Scanning downward from bit 11 makes the first hit the highest bit.
                if (req_q[cnt_q] && (first_q == 4'd0)) begin
                    first_d = cnt_q + 4'd1;
                end else if (req_q[cnt_q] && (second_q == 4'd0)) begin
                    second_d = cnt_q + 4'd1;
                end else begin
                    first_d  = first_q;
                    second_d = second_q;
                end
                // Bit 0 is processed on the same edge that enters DONE.
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = SCAN;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = 4'd0;
                first_d  = 4'd0;
                second_d = 4'd0;
                req_d    = 12'd0;
            end
        endcase

        // Outputs are computed from the next state so they leave a flop directly.
        o_ready_d = (state_d == IDLE);
        o_valid_d = (state_d == DONE);
        if (state_d == DONE) begin
            o_first_d  = first_d;
            o_second_d = second_d;
            o_none_d   = (first_d == 4'd0);
        end else begin
            o_first_d  = 4'd0;
            o_second_d = 4'd0;
            o_none_d   = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            req_q      <= 12'd0;
            cnt_q      <= 4'd0;
            first_q    <= 4'd0;
            second_q   <= 4'd0;
            o_ready_q  <= 1'b1;
            o_valid_q  <= 1'b0;
            o_first_q  <= 4'd0;
            o_second_q <= 4'd0;
            o_none_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            second_q   <= second_d;
            o_ready_q  <= o_ready_d;
            o_valid_q  <= o_valid_d;
            o_first_q  <= o_first_d;
            o_second_q <= o_second_d;
            o_none_q   <= o_none_d;
        end
    end

    assign o_ready  = o_ready_q;
    assign o_valid  = o_valid_q;
    assign o_first  = o_first_q;
    assign o_second = o_second_q;
    assign o_none   = o_none_q;

endmodule
